// File: rtl/sha1_mm_csr_chain_if.sv
// Avalon-MM CSR bus between the system master and the SHA-1 chaining front end.
interface sha1_mm_csr_chain_if;
    logic        write;
    logic        read;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output write, read, address, writedata, input readdata, irq);
    modport slave  (input write, read, address, writedata, output readdata, irq);
endinterface

// File: rtl/sha1_mm_csr_chain.sv
// CSR front end for a SHA-1 compression core: message/digest registers, chaining
// across blocks, status with W1C bits, level irq and a core-hang timeout.
module sha1_mm_csr_chain #(
    parameter int unsigned  TIMEOUT_CYCLES = 255,
    parameter int unsigned  CNT_W          = 32,
    parameter logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0
) (
    input  logic                  clk,
    input  logic                  reset,
    sha1_mm_csr_chain_if.slave    bus,
    output logic                  core_start,
    output logic [511:0]          core_block,
    output logic [159:0]          core_hin,
    input  logic                  core_done,
    input  logic [159:0]          core_digest
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t             state;
    logic [15:0][31:0]  msg;       // MSG i lives in msg[15-i] so MSG0 lands on the block MSBs
    logic [159:0]       digest;
    logic [CNT_W-1:0]   blk_cnt;
    logic [31:0]        wait_cnt;
    logic               mode, irq_en, run_mode;
    logic               done, timeout, wr_err;

    logic        busy, wr_ctrl, wr_stat, wr_msg, start_req, hw_done, hw_to;
    logic [3:0]  msg_idx;
    logic [31:0] rd_val;

    assign busy      = (state != IDLE);
    assign wr_ctrl   = bus.write && (bus.address == 5'd0);
    assign wr_stat   = bus.write && (bus.address == 5'd1);
    assign wr_msg    = bus.write && (bus.address >= 5'd2) && (bus.address <= 5'd17);
    assign msg_idx   = 4'(5'd17 - bus.address);
    assign start_req = wr_ctrl && bus.writedata[0] && !busy;
    assign hw_done   = (state == WAIT) && core_done;
    // core_done in the limit cycle takes priority over the timeout
    assign hw_to     = (state == WAIT) && !core_done && (TIMEOUT_CYCLES != 0)
                       && (wait_cnt == TIMEOUT_CYCLES);
    assign bus.irq   = irq_en & (done | timeout);

    always_comb begin
        rd_val = '0;
        case (bus.address)
            5'd0:  rd_val = {29'b0, irq_en, mode, 1'b0};
            5'd1:  rd_val = {28'b0, wr_err, timeout, done, busy};
            5'd18: rd_val = digest[159:128];
            5'd19: rd_val = digest[127:96];
            5'd20: rd_val = digest[95:64];
            5'd21: rd_val = digest[63:32];
            5'd22: rd_val = digest[31:0];
            5'd23: rd_val = 32'(blk_cnt);
            default: if (bus.address >= 5'd2 && bus.address <= 5'd17) rd_val = msg[msg_idx];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            msg          <= '0;
            digest       <= '0;
            blk_cnt      <= '0;
            wait_cnt     <= '0;
            mode         <= 1'b0;
            irq_en       <= 1'b0;
            run_mode     <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            wr_err       <= 1'b0;
            core_start   <= 1'b0;
            core_block   <= '0;
            core_hin     <= '0;
            bus.readdata <= '0;
        end else begin
            bus.readdata <= bus.read ? rd_val : 32'd0;
            core_start   <= 1'b0;

            if (wr_ctrl) begin
                mode   <= bus.writedata[1];
                irq_en <= bus.writedata[2];
            end
            if (wr_msg && !busy) msg[msg_idx] <= bus.writedata;

            // clears first, hardware sets last so a set in the same cycle wins
            if (wr_stat) begin
                if (bus.writedata[1]) done    <= 1'b0;
                if (bus.writedata[2]) timeout <= 1'b0;
                if (bus.writedata[3]) wr_err  <= 1'b0;
            end
            if (start_req) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end
            if (hw_done) done    <= 1'b1;
            if (hw_to)   timeout <= 1'b1;
            if (busy && (wr_msg || (wr_ctrl && bus.writedata[0]))) wr_err <= 1'b1;

            case (state)
                IDLE: if (start_req) begin
                    state      <= LAUNCH;
                    core_start <= 1'b1;
                    core_block <= msg;
                    core_hin   <= bus.writedata[1] ? digest : IV;
                    run_mode   <= bus.writedata[1];
                end
                LAUNCH: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (core_done) begin
                        digest  <= core_digest;
                        blk_cnt <= run_mode ? blk_cnt + 1'b1 : CNT_W'(1);
                        state   <= IDLE;
                    end else if (hw_to) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_mm_csr_chain.sv
// Bench for sha1_mm_csr_chain: register table, known-answer SHA-1 vectors,
// irq/timeout/busy/reset sequences and randomized chained blocks vs a reference model.
module tb_sha1_mm_csr_chain;
    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         core_start;
    logic [511:0] core_block;
    logic [159:0] core_hin;
    logic         core_done = 1'b0;
    logic [159:0] core_digest = '0;

    sha1_mm_csr_chain_if bus();

    sha1_mm_csr_chain #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .core_start(core_start), .core_block(core_block), .core_hin(core_hin),
        .core_done(core_done), .core_digest(core_digest)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int core_lat = 0, start_cnt = 0, pulse_req_n = 0;
    logic hang = 1'b0;
    logic [31:0]  m_msg [16];
    logic [159:0] m_digest;
    logic [31:0]  m_cnt;

    function automatic logic [159:0] sha1_f(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        {a, b, c, d, e} = h;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    function automatic logic [511:0] pack_msg();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = m_msg[i];
        return b;
    endfunction

    // Behavioural compression core: answers each launch after a latency, unless hung.
    initial begin : core_model
        logic [159:0] h;
        logic [511:0] b;
        int lat, ack_n;
        ack_n = 0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (pulse_req_n != ack_n) begin
                ack_n++;
                core_done = 1'b1;
                core_digest = {5{32'hbad00bad}};
            end else if (core_start && !hang) begin
                h = core_hin;
                b = core_block;
                lat = (core_lat == 0) ? int'($urandom_range(1, 6)) : core_lat;
                repeat (lat) @(negedge clk);
                core_done = 1'b1;
                core_digest = sha1_f(h, b);
            end
        end
    end

    always @(negedge clk) if (core_start) start_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk); bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(negedge clk); bus.write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk); bus.read = 1'b1; bus.address = a;
        @(negedge clk); bus.read = 1'b0; d = bus.readdata;
    endtask

    task automatic mwr(input int idx, input logic [31:0] d);
        wr(5'(2 + idx), d);
        m_msg[idx] = d;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        st = 32'h1;
        for (int i = 0; i < 40 && st[0]; i++) rd(5'd1, st);
        chk("busy_clears", {31'b0, st[0]}, 32'd0);
    endtask

    task automatic check_digest(input string tag, input logic [159:0] exp);
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            rd(5'(18 + i), d);
            chk(tag, d, exp[159-32*i -: 32]);
        end
    endtask

    task automatic run_block(input logic [2:0] ctrl, output logic [31:0] st);
        logic [159:0] base;
        base = ctrl[1] ? m_digest : IV;
        wr(5'd0, {29'b0, ctrl});
        wait_idle(st);
        m_digest = sha1_f(base, pack_msg());
        m_cnt = ctrl[1] ? m_cnt + 32'd1 : 32'd1;
    endtask

    typedef struct {
        logic        is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [18];
    logic [31:0] st, d;
    logic got;
    int s0;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writedata = '0;
        for (int i = 0; i < 16; i++) m_msg[i] = '0;
        m_digest = '0; m_cnt = '0;

        vecs[0]  = '{0, 5'd0,  32'h0,        32'h0};
        vecs[1]  = '{0, 5'd1,  32'h0,        32'h0};
        vecs[2]  = '{0, 5'd18, 32'h0,        32'h0};
        vecs[3]  = '{0, 5'd23, 32'h0,        32'h0};
        vecs[4]  = '{1, 5'd2,  32'h12345678, 32'h0};
        vecs[5]  = '{0, 5'd2,  32'h0,        32'h12345678};
        vecs[6]  = '{1, 5'd17, 32'ha5a5a5a5, 32'h0};
        vecs[7]  = '{0, 5'd17, 32'h0,        32'ha5a5a5a5};
        vecs[8]  = '{1, 5'd25, 32'hffffffff, 32'h0};
        vecs[9]  = '{0, 5'd25, 32'h0,        32'h0};
        vecs[10] = '{1, 5'd18, 32'h0000ffff, 32'h0};
        vecs[11] = '{0, 5'd18, 32'h0,        32'h0};
        vecs[12] = '{1, 5'd0,  32'h6,        32'h0};
        vecs[13] = '{0, 5'd0,  32'h0,        32'h6};
        vecs[14] = '{1, 5'd1,  32'hf,        32'h0};
        vecs[15] = '{0, 5'd1,  32'h0,        32'h0};
        vecs[16] = '{1, 5'd0,  32'h0,        32'h0};
        vecs[17] = '{0, 5'd31, 32'h0,        32'h0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_readdata", bus.readdata, 32'd0);
        chk("rst_irq", {31'b0, bus.irq}, 32'd0);
        chk("rst_core_start", {31'b0, core_start}, 32'd0);
        chk("rst_core_block", {31'b0, |core_block}, 32'd0);
        chk("rst_core_hin", {31'b0, |core_hin}, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
            else begin
                rd(vecs[i].addr, d);
                chk($sformatf("table_%0d", i), d, vecs[i].exp);
            end
        end
        @(negedge clk);
        chk("readdata_idle_zero", bus.readdata, 32'd0);

        // "abc" single block
        for (int i = 0; i < 16; i++) mwr(i, 32'h0);
        mwr(0, 32'h61626380); mwr(15, 32'h00000018);
        run_block(3'b001, st);
        chk("abc_status", st, 32'h2);
        check_digest("abc_digest", 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        rd(5'd23, d); chk("abc_cnt", d, 32'd1);

        // two-block message, second block chained from DIGEST
        mwr(0, 32'h61626364); mwr(1, 32'h62636465); mwr(2, 32'h63646566); mwr(3, 32'h64656667);
        mwr(4, 32'h65666768); mwr(5, 32'h66676869); mwr(6, 32'h6768696a); mwr(7, 32'h68696a6b);
        mwr(8, 32'h696a6b6c); mwr(9, 32'h6a6b6c6d); mwr(10, 32'h6b6c6d6e); mwr(11, 32'h6c6d6e6f);
        mwr(12, 32'h6d6e6f70); mwr(13, 32'h6e6f7071); mwr(14, 32'h80000000); mwr(15, 32'h0);
        run_block(3'b001, st);
        for (int i = 0; i < 15; i++) mwr(i, 32'h0);
        mwr(15, 32'h000001c0);
        run_block(3'b011, st);
        check_digest("two_blk_digest", 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
        rd(5'd23, d); chk("two_blk_cnt", d, 32'd2);

        // irq follows DONE one cycle after core_done, W1C clears it
        core_lat = 3;
        wr(5'd0, 32'h5);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            if (core_done) got = 1'b1;
        end
        chk("irq_done_seen", {31'b0, got}, 32'd1);
        chk("irq_before_done", {31'b0, bus.irq}, 32'd0);
        @(negedge clk); #1;
        chk("irq_after_done", {31'b0, bus.irq}, 32'd1);
        m_digest = sha1_f(IV, pack_msg()); m_cnt = 32'd1;
        wr(5'd1, 32'h2);
        chk("irq_w1c", {31'b0, bus.irq}, 32'd0);
        rd(5'd1, d); chk("done_w1c", d, 32'h0);

        // W1C of DONE landing on the core_done cycle: set wins
        core_lat = 4;
        wr(5'd0, 32'h5);
        repeat (3) @(negedge clk);
        wr(5'd1, 32'h2);
        wait_idle(st);
        chk("w1c_vs_set", st, 32'h2);
        chk("w1c_vs_set_irq", {31'b0, bus.irq}, 32'd1);
        m_digest = sha1_f(IV, pack_msg()); m_cnt = 32'd1;
        wr(5'd1, 32'he);

        // hung core: timeout, digest kept, late core_done ignored
        hang = 1'b1;
        wr(5'd0, 32'h1);
        rd(5'd1, d); chk("hang_busy", d, 32'h1);
        wait_idle(st);
        chk("hang_status", st, 32'h4);
        check_digest("hang_digest", m_digest);
        pulse_req_n++;
        repeat (4) @(negedge clk);
        rd(5'd1, d); chk("late_done_status", d, 32'h4);
        rd(5'd23, d); chk("late_done_cnt", d, m_cnt);
        check_digest("late_done_digest", m_digest);
        hang = 1'b0;
        wr(5'd1, 32'h4);

        // writes while busy are dropped and flagged
        core_lat = 6;
        s0 = start_cnt;
        wr(5'd0, 32'h1);
        wr(5'd5, 32'hdeadbeef);
        wr(5'd0, 32'h5);
        wait_idle(st);
        m_digest = sha1_f(IV, pack_msg()); m_cnt = 32'd1;
        chk("busy_one_start", 32'(start_cnt - s0), 32'd1);
        chk("busy_status", st, 32'ha);
        rd(5'd5, d); chk("busy_msg3", d, m_msg[3]);
        rd(5'd0, d); chk("busy_ctrl", d, 32'h4);
        check_digest("busy_digest", m_digest);
        wr(5'd1, 32'he);
        wr(5'd0, 32'h0);

        // randomized chained blocks against the reference model
        core_lat = 0;
        for (int it = 0; it < 12; it++) begin
            logic [2:0] ctrl;
            int idx;
            for (int j = 0; j < int'($urandom_range(1, 4)); j++)
                mwr(int'($urandom_range(0, 15)), $urandom);
            idx = int'($urandom_range(0, 15));
            rd(5'(2 + idx), d); chk("rnd_msg", d, m_msg[idx]);
            ctrl = {1'($urandom), 1'($urandom), 1'b1};
            run_block(ctrl, st);
            chk("rnd_status", st, 32'h2);
            chk("rnd_irq", {31'b0, bus.irq}, {31'b0, ctrl[2]});
            check_digest("rnd_digest", m_digest);
            rd(5'd23, d); chk("rnd_cnt", d, m_cnt);
        end

        // reset during WAIT, then a stray core_done
        core_lat = 6;
        wr(5'd0, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("wrst_readdata", bus.readdata, 32'd0);
        chk("wrst_core_start", {31'b0, core_start}, 32'd0);
        chk("wrst_irq", {31'b0, bus.irq}, 32'd0);
        chk("wrst_core_block", {31'b0, |core_block}, 32'd0);
        rd(5'd1, d);  chk("wrst_status", d, 32'h0);
        rd(5'd18, d); chk("wrst_digest", d, 32'h0);
        rd(5'd23, d); chk("wrst_cnt", d, 32'h0);
        rd(5'd2, d);  chk("wrst_msg0", d, 32'h0);
        rd(5'd0, d);  chk("wrst_ctrl", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
